commit_trace_buffer: RTL
========================

// Module: commit_trace_buffer
// PURPOSE
//  Synthesisable successor to the simulation-only PC/instruction dump: records retired-instruction
//  trace entries {pc, inst, reg writeback} into an on-chip FIFO with trigger/stop control.
//  Sits beside the multi-cycle CPU core in the SoC. Drains over a valid/ready stream to a debug port.
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two, >=2
//  DW         32  writeback data width
//  REG_AW     5   register address width (2**REG_AW architectural regs)
//  STOP_CNT   0   entries to record after trigger before stopping; 0 = never stop
//  OVERWRITE  0   full policy: 0 = drop new entry, 1 = overwrite oldest
// PORTS
//  clk_in       in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  en           in   1       tracing enable; 0 forces state IDLE, no capture
//  mode         in   1       0 = capture on PC change, 1 = capture on commit_valid strobe
//  commit_valid in   1       retire strobe (mode 1 only)
//  pc           in   32      current core PC
//  inst         in   32      current core instruction
//  wb_en        in   1       register-file write this cycle
//  wb_addr      in   REG_AW  write address
//  wb_data      in   DW      write data
//  trig_en      in   1       1 = wait for trig_pc before recording
//  trig_pc      in   32      trigger PC
//  clr_ovf      in   1       clears overflow and drop_cnt
//  out_valid    out  1       head entry available
//  out_ready    in   1       consumer accepts head entry
//  out_pc/out_inst  out 32   head entry pc / instruction
//  out_wb_en/out_wb_addr/out_wb_data  out 1/REG_AW/DW   head entry writeback
//  level        out  $clog2(DEPTH)+1  entries stored
//  overflow     out  1       sticky: an entry was lost
//  drop_cnt     out  16      lost entries, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, out_valid=0, level=0, overflow=0, drop_cnt=0, state IDLE,
//   prev_pc=0, prev_inst=0, pending wb cleared; out_* data = 0.
//  Capture event: mode 0 -> pc != prev_pc; entry = {prev_pc, prev_inst, pending wb}; prev_* <= pc/inst
//   every cycle (also while not recording). mode 1 -> commit_valid=1; entry = {pc, inst, current wb}.
//  Pending wb (mode 0): latches wb_en/addr/data whenever wb_en=1; cleared on capture event;
//   wb_en=1 in the event cycle goes to the NEXT entry.
//  FSM: IDLE -(en & !trig_en)-> RUN; IDLE -(en & trig_en)-> ARMED;
//   ARMED -(event & entry pc==trig_pc)-> RUN, that entry recorded; RUN -(recorded==STOP_CNT, STOP_CNT!=0)-> DONE;
//   any state -(!en)-> IDLE next cycle. Record only in RUN or trigger cycle; recorded counter reset on IDLE.
//  Latency: entry captured at edge N is on out_* with out_valid=1 after edge N (visible cycle N+1).
//  Pop: out_valid & out_ready at edge; out_* show next entry combinationally from storage.
//  Push+pop same cycle: both performed, level unchanged, also when full.
//  Full, push, no pop: OVERWRITE=0 -> new entry dropped; OVERWRITE=1 -> oldest discarded, new stored.
//   Either case: overflow<=1, drop_cnt+1 (saturating). Empty: out_valid=0, pop ignored.
//  Pointers wrap modulo DEPTH; level = 0..DEPTH. clr_ovf same cycle as drop: clear wins.
//  en falling mid-operation: stored entries kept and drainable; no further capture.
// TESTING
//  1 mode0, trig_en=0, pc 0->4->8 with inst A,B -> entries {0,0},{4,A} in order, level 2.
//  2 mode1, wb_en=1 addr 3 data 0x55 with commit_valid -> entry wb_en=1, addr 3, data 0x55.
//  3 trig_en=1, trig_pc=0x10, STOP_CNT=2, pcs 0x8,0x10,0x14,0x18 -> entries 0x10,0x14 only, state DONE.
//  4 DEPTH=4, OVERWRITE=0, 6 events, no pop -> level 4, first 4 kept, overflow=1, drop_cnt=2.
//  5 OVERWRITE=1 same stimulus -> last 4 kept; then clr_ovf -> overflow=0, drop_cnt=0.
//  6 full FIFO, out_ready=1 with event same cycle -> level stays 4, no drop; reset mid-run -> all cleared.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Retired-instruction trace recorder: captures {pc, inst, writeback} entries into a FIFO
// under trigger/stop control and drains them over a valid/ready stream.
module commit_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int DW        = 32,
  parameter int REG_AW    = 5,
  parameter int STOP_CNT  = 0,
  parameter int OVERWRITE = 0
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     commit_valid,
  input  logic [31:0]              pc,
  input  logic [31:0]              inst,
  input  logic                     wb_en,
  input  logic [REG_AW-1:0]        wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_wb_en,
  output logic [REG_AW-1:0]        out_wb_addr,
  output logic [DW-1:0]            out_wb_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          EW       = 64 + 1 + REG_AW + DW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);
  localparam logic [31:0] STOP_LIM = 32'(STOP_CNT);
  localparam logic        OVW      = (OVERWRITE != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [31:0]       rec_cnt_r, rec_cnt_inc_s;
  logic [31:0]       prev_pc_r, prev_inst_r;
  logic              pend_en_r;
  logic [REG_AW-1:0] pend_addr_r;
  logic [DW-1:0]     pend_data_r;
  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [AW:0]       level_r, level_nxt_s;
  logic              overflow_r;
  logic [15:0]       drop_cnt_r;

  logic              evt_s, trig_hit_s, rec_s, full_s, pop_s, drop_s, push_s, adv_rd_s, stop_hit_s;
  logic [EW-1:0]     entry_s;

  // Capture event and entry contents depend on the capture mode
  always_comb begin
    evt_s   = 1'b0;
    entry_s = '0;
    if (mode) begin
      evt_s   = commit_valid;
      entry_s = {pc, inst, wb_en, wb_addr, wb_data};
    end else begin
      evt_s   = (pc != prev_pc_r);
      entry_s = {prev_pc_r, prev_inst_r, pend_en_r, pend_addr_r, pend_data_r};
    end
  end

  assign trig_hit_s    = (entry_s[EW-1 -: 32] == trig_pc);
  assign rec_s         = en & evt_s & ((state_r == RUN) | ((state_r == ARMED) & trig_hit_s));
  assign full_s        = (level_r == FULL_LVL);
  assign pop_s         = (level_r != '0) & out_ready;
  assign drop_s        = rec_s & full_s & ~pop_s;
  // With overwrite, a drop still writes: the oldest slot is reused and the read side skips it
  assign push_s        = rec_s & (~drop_s | OVW);
  assign adv_rd_s      = pop_s | (drop_s & OVW);
  assign rec_cnt_inc_s = rec_cnt_r + 32'd1;
  assign stop_hit_s    = (STOP_LIM != 32'd0) & rec_s & (rec_cnt_inc_s >= STOP_LIM);

  // Occupancy update
  always_comb begin
    level_nxt_s = level_r;
    if (push_s && !pop_s && !full_s) begin
      level_nxt_s = level_r + ONE_LVL;
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - ONE_LVL;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Trace control next state
  always_comb begin
    state_nxt_s = state_r;
    if (!en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = trig_en ? ARMED : RUN;
        ARMED:   state_nxt_s = rec_s ? (stop_hit_s ? DONE : RUN) : ARMED;
        RUN:     state_nxt_s = stop_hit_s ? DONE : RUN;
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Trace control state and recorded-entry counter
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      rec_cnt_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE) begin
        rec_cnt_r <= 32'd0;
      end else if (rec_s) begin
        rec_cnt_r <= rec_cnt_inc_s;
      end
    end
  end

  // Previous pc/inst and the pending writeback for PC-change capture
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      prev_pc_r   <= 32'd0;
      prev_inst_r <= 32'd0;
      pend_en_r   <= 1'b0;
      pend_addr_r <= '0;
      pend_data_r <= '0;
    end else begin
      prev_pc_r   <= pc;
      prev_inst_r <= inst;
      if (!mode) begin
        if (evt_s) begin
          pend_en_r   <= wb_en;
          pend_addr_r <= wb_en ? wb_addr : '0;
          pend_data_r <= wb_en ? wb_data : '0;
        end else if (wb_en) begin
          pend_en_r   <= 1'b1;
          pend_addr_r <= wb_addr;
          pend_data_r <= wb_data;
        end
      end
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + ONE_PTR;
      end
      if (adv_rd_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      level_r <= level_nxt_s;
    end
  end

  // Loss bookkeeping; a clear in the same cycle as a drop takes priority
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 16'hFFFF) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign {out_pc, out_inst, out_wb_en, out_wb_addr, out_wb_data} = mem_r[rd_ptr_r];
  assign out_valid = (level_r != '0);
  assign level     = level_r;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;

endmodule
